// File: rtl/nlx_sram_ctrl_pkg.sv
// Shared widths, command record and helpers for the SRAM request front-end.
package nlx_sram_ctrl_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  typedef struct packed {
    logic [BE_W-1:0]   we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } nlx_sram_cmd_t;

  // An all-zero byte-enable mask is a read.
  function automatic logic is_read(input logic [BE_W-1:0] we);
    return (we == '0);
  endfunction

endpackage

// File: rtl/nlx_sram_rsp_fifo.sv
// Read-response FIFO with a registered head word; occupancy decides full/empty.
module nlx_sram_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    rd_next;
  logic             push_en;
  logic             pop_en;

  assign empty   = (count == '0);
  assign pop_en  = pop && !empty;
  assign push_en = push && ((count < CW'(DEPTH)) || pop_en);
  assign rd_next = rd_ptr + PW'(pop_en);

  always_ff @(posedge clk) begin
    if (push_en) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // The head register preloads whichever word sits at the next read pointer,
  // taking the incoming word when it lands exactly there this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      pop_data <= '0;
    end else begin
      if (push_en) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      rd_ptr   <= rd_next;
      count    <= count + CW'(push_en) - CW'(pop_en);
      pop_data <= (push_en && (wr_ptr == rd_next)) ? push_data : mem[rd_next];
    end
  end

endmodule

// File: rtl/nlx_sram_ctrl.sv
// SRAM request front-end: registered issue stage, read-tag pipeline,
// credit counter and in-order read-response FIFO.
module nlx_sram_ctrl
  import nlx_sram_ctrl_pkg::*;
#(
  parameter int RD_LAT    = 1,
  parameter int RSP_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [BE_W-1:0]   req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [BE_W-1:0]   sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  localparam int CW = $clog2(RSP_DEPTH) + 1;

  nlx_sram_cmd_t issue_q;
  nlx_sram_cmd_t req_cmd;
  logic [CW-1:0] credit_cnt;
  logic [CW-1:0] rsp_count;
  logic [RD_LAT:0] tag;
  logic          accept;
  logic          rd_accept;
  logic          rsp_pop;
  logic          fifo_empty;

  assign req_ready = (credit_cnt < CW'(RSP_DEPTH));
  assign accept    = req_valid && req_ready;
  assign rd_accept = accept && is_read(req_we);
  assign rsp_valid = !fifo_empty;
  assign rsp_pop   = rsp_valid && rsp_ready;

  assign req_cmd = '{we: req_we, addr: req_addr, wdata: req_wdata};

  assign sram_we    = issue_q.we;
  assign sram_addr  = issue_q.addr;
  assign sram_wdata = issue_q.wdata;

  // Idle cycles keep addr/wdata and only drop the byte enables,
  // which presents a harmless read to the SRAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_q <= '0;
    end else if (accept) begin
      issue_q <= req_cmd;
    end else begin
      issue_q.we <= '0;
    end
  end

  // tag[i] marks that the command issued i edges ago was a real read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag <= '0;
    end else begin
      tag <= {tag[RD_LAT-1:0], rd_accept};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credit_cnt <= '0;
    end else begin
      case ({rd_accept, rsp_pop})
        2'b10:   credit_cnt <= credit_cnt + CW'(1);
        2'b01:   credit_cnt <= credit_cnt - CW'(1);
        default: credit_cnt <= credit_cnt;
      endcase
    end
  end

  nlx_sram_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (DATA_W)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tag[RD_LAT]),
    .push_data (sram_rdata),
    .pop       (rsp_pop),
    .pop_data  (rsp_rdata),
    .empty     (fifo_empty),
    .count     (rsp_count)
  );

  // Credits reserve a slot for every tagged read, so a push never meets a full FIFO.
  always_comb begin
    if (!rst) begin
      assert (!(tag[RD_LAT] && !rsp_pop && (rsp_count == CW'(RSP_DEPTH))));
    end
  end

endmodule

// File: tb/tb_nlx_sram_ctrl.sv
// Bench: two builds (RD_LAT=1 and RD_LAT=3) driven by shared stimulus, each
// checked every cycle against a reference memory plus expected-response queue.
module tb_nlx_sram_ctrl;

  typedef struct {
    logic [31:0] data;
    int          rdy;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [3:0]  req_we;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_ready;

  logic        req_ready_a  [2];
  logic        rsp_valid_a  [2];
  logic [31:0] rsp_rdata_a  [2];
  logic [3:0]  sram_we_a    [2];
  logic [15:0] sram_addr_a  [2];
  logic [31:0] sram_wdata_a [2];
  logic [31:0] sram_rdata_a [2];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  task automatic check(input int lane, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL lane%0d %s t=%0t got=%h expected=%h", lane, name, $time, act, exp);
    end
  endtask

  function automatic int lat_of(input int lane);
    return (lane == 0) ? 1 : 3;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int LAT = (g == 0) ? 1 : 3;

    nlx_sram_ctrl #(
      .RD_LAT    (LAT),
      .RSP_DEPTH (4)
    ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready_a[g]),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid_a[g]),
      .rsp_ready  (rsp_ready),
      .rsp_rdata  (rsp_rdata_a[g]),
      .sram_we    (sram_we_a[g]),
      .sram_addr  (sram_addr_a[g]),
      .sram_wdata (sram_wdata_a[g]),
      .sram_rdata (sram_rdata_a[g])
    );

    // Synchronous SRAM: samples the port at an edge, data emerges LAT edges later.
    logic [31:0] mem  [256] = '{default: '0};
    logic [31:0] pipe [LAT];

    always @(posedge clk) begin
      for (int b = 0; b < 4; b++)
        if (sram_we_a[g][b]) mem[sram_addr_a[g][7:0]][8*b +: 8] <= sram_wdata_a[g][8*b +: 8];
      pipe[0] <= mem[sram_addr_a[g][7:0]];
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign sram_rdata_a[g] = pipe[LAT-1];

    // Reference: memory updated in acceptance order; each accepted read queues
    // the value it must return and the first cycle it may be visible.
    logic [31:0] ref_mem [256] = '{default: '0};
    exp_t        q [$];
    int          cyc = 0;
    logic [3:0]  last_we = '0;
    logic [15:0] last_addr = '0;
    logic [31:0] last_wdata = '0;
    logic        exp_valid;
    logic        exp_ready;

    always @(negedge clk) begin
      cyc++;
      if (rst) begin
        q.delete();
        last_we = '0;
        last_addr = '0;
        last_wdata = '0;
        check(g, "rst_req_ready", 32'(req_ready_a[g]), 32'd1);
        check(g, "rst_rsp_valid", 32'(rsp_valid_a[g]), 32'd0);
        check(g, "rst_rsp_rdata", rsp_rdata_a[g], 32'd0);
        check(g, "rst_sram_we", 32'(sram_we_a[g]), 32'd0);
        check(g, "rst_sram_addr", 32'(sram_addr_a[g]), 32'd0);
        check(g, "rst_sram_wdata", sram_wdata_a[g], 32'd0);
      end else begin
        exp_valid = (q.size() > 0) && (q[0].rdy <= cyc);
        exp_ready = (q.size() < 4);
        check(g, "rsp_valid", 32'(rsp_valid_a[g]), 32'(exp_valid));
        if (exp_valid) check(g, "rsp_rdata", rsp_rdata_a[g], q[0].data);
        check(g, "req_ready", 32'(req_ready_a[g]), 32'(exp_ready));
        check(g, "sram_we", 32'(sram_we_a[g]), 32'(last_we));
        check(g, "sram_addr", 32'(sram_addr_a[g]), 32'(last_addr));
        check(g, "sram_wdata", sram_wdata_a[g], last_wdata);
        if (exp_valid && rsp_ready) void'(q.pop_front());
        if (req_valid && exp_ready) begin
          if (req_we == 4'h0) begin
            q.push_back('{data: ref_mem[req_addr[7:0]], rdy: cyc + LAT + 2});
          end else begin
            for (int b = 0; b < 4; b++)
              if (req_we[b]) ref_mem[req_addr[7:0]][8*b +: 8] = req_wdata[8*b +: 8];
          end
          last_we    = req_we;
          last_addr  = req_addr;
          last_wdata = req_wdata;
        end else begin
          last_we = '0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] we, input logic [15:0] a, input logic [31:0] d);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    tick();
    req_valid = 1'b0;
  endtask

  // Called right after a read's accepting edge; counts edges until rsp_valid.
  task automatic measure(input logic [31:0] exp_d);
    int   n;
    logic seen [2];
    seen[0] = 1'b0;
    seen[1] = 1'b0;
    n = 0;
    while (n < 12 && !(seen[0] && seen[1])) begin
      for (int l = 0; l < 2; l++) begin
        if (!seen[l] && rsp_valid_a[l]) begin
          seen[l] = 1'b1;
          check(l, "rsp_latency", 32'(n), 32'(lat_of(l) + 1));
          check(l, "rsp_data_lit", rsp_rdata_a[l], exp_d);
        end
      end
      if (!(seen[0] && seen[1])) begin
        tick();
        n++;
      end
    end
    for (int l = 0; l < 2; l++)
      if (!seen[l]) check(l, "rsp_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc [2];
    int acc0;

    rst = 1'b1;
    req_valid = 1'b0;
    req_we = '0;
    req_addr = '0;
    req_wdata = '0;
    rsp_ready = 1'b1;
    repeat (3) tick();
    for (int l = 0; l < 2; l++) begin
      check(l, "init_req_ready", 32'(req_ready_a[l]), 32'd1);
      check(l, "init_rsp_valid", 32'(rsp_valid_a[l]), 32'd0);
    end
    rst = 1'b0;
    tick();

    // Write then read back the same word.
    issue(4'hF, 16'h0010, 32'hDEAD_BEEF);
    issue(4'h0, 16'h0010, 32'h0);
    measure(32'hDEAD_BEEF);
    repeat (3) tick();

    // Partial byte-enable merge.
    issue(4'hF, 16'h0020, 32'h1122_3344);
    issue(4'b1001, 16'h0020, 32'hAA00_00BB);
    issue(4'h0, 16'h0020, 32'h0);
    measure(32'hAA22_33BB);
    repeat (3) tick();

    // Backpressure: six back-to-back reads against four credits.
    rsp_ready = 1'b0;
    acc[0] = 0;
    acc[1] = 0;
    for (int i = 0; i < 6; i++) begin
      req_valid = 1'b1;
      req_we    = 4'h0;
      req_addr  = 16'(i);
      for (int l = 0; l < 2; l++) acc[l] += 32'(req_ready_a[l]);
      tick();
    end
    req_valid = 1'b0;
    repeat (6) tick();
    for (int l = 0; l < 2; l++) begin
      check(l, "bp_accepted", 32'(acc[l]), 32'd4);
      check(l, "bp_ready_low", 32'(req_ready_a[l]), 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    for (int l = 0; l < 2; l++) check(l, "bp_ready_after_pop", 32'(req_ready_a[l]), 32'd1);
    repeat (8) tick();

    // Fill to full, then stream reads with accept and pop in the same cycle.
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_we    = 4'h0;
    for (int i = 0; i < 10; i++) begin
      req_addr = 16'($urandom_range(0, 15));
      tick();
    end
    check(0, "full_ready_low", 32'(req_ready_a[0]), 32'd0);
    rsp_ready = 1'b1;
    acc0 = 0;
    for (int i = 0; i < 33; i++) begin
      req_addr = 16'($urandom_range(0, 31));
      acc0 += 32'(req_ready_a[0]);
      tick();
    end
    check(0, "stream_accepted", 32'(acc0), 32'd32);
    req_valid = 1'b0;
    repeat (10) tick();

    // Random mix; stalls in the first part, free-running consumer later.
    for (int i = 0; i < 700; i++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_we    = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      req_addr  = 16'($urandom_range(0, 15));
      req_wdata = $urandom;
      rsp_ready = (i >= 400) ? 1'b1 : ($urandom_range(0, 3) != 0);
      tick();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (10) tick();

    // Mid-stream reset with three reads outstanding.
    rsp_ready = 1'b0;
    issue(4'h0, 16'h0005, 32'h0);
    issue(4'h0, 16'h0006, 32'h0);
    issue(4'h0, 16'h0007, 32'h0);
    rst = 1'b1;
    #1;
    for (int l = 0; l < 2; l++) begin
      check(l, "async_rst_rsp_valid", 32'(rsp_valid_a[l]), 32'd0);
      check(l, "async_rst_req_ready", 32'(req_ready_a[l]), 32'd1);
      check(l, "async_rst_sram_we", 32'(sram_we_a[l]), 32'd0);
      check(l, "async_rst_sram_addr", 32'(sram_addr_a[l]), 32'd0);
      check(l, "async_rst_rsp_rdata", rsp_rdata_a[l], 32'd0);
    end
    tick();
    tick();
    rst = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      for (int l = 0; l < 2; l++) check(l, "post_rst_quiet", 32'(rsp_valid_a[l]), 32'd0);
      tick();
    end
    for (int l = 0; l < 2; l++) check(l, "post_rst_ready", 32'(req_ready_a[l]), 32'd1);
    issue(4'hF, 16'h0030, 32'h1234_5678);
    issue(4'h0, 16'h0030, 32'h0);
    measure(32'h1234_5678);
    repeat (6) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
